// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one 32-bit ALU between two requesters (req0, req1).
// Optional ALU_ARB_DIV0_GUARD_EN: answers DIV-by-zero locally without issuing it to the ALU.
module alu_arbiter #(
   parameter int unsigned ALU_LATENCY = 1,
   parameter logic [3:0]  IDLE_CTRL   = 4'b1111
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_ctrl,
   input  logic [31:0] req0_op1,
   input  logic [31:0] req0_op2,
   input  logic [4:0]  req0_shamnt,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_ctrl,
   input  logic [31:0] req1_op1,
   input  logic [31:0] req1_op2,
   input  logic [4:0]  req1_shamnt,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic [7:0]  rsp0_status,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic [7:0]  rsp1_status,
   output logic [3:0]  alu_ctrl,
   output logic [31:0] alu_op1,
   output logic [31:0] alu_op2,
   output logic [4:0]  alu_shamnt,
   input  logic [31:0] alu_result,
   input  logic [7:0]  alu_status,
   output logic        busy
);

   localparam logic [3:0] CntInit = 4'(ALU_LATENCY - 1);
   localparam logic [3:0] DivCtrl = 4'b1001;

   typedef enum logic [1:0] {StIdle, StSetup, StExec, StResp} state_e;

   state_e      state_q, state_d;
   logic        rr_ptr_q, rr_ptr_d;
   logic        owner_q;
   logic [3:0]  ctrl_q;
   logic [31:0] op1_q, op2_q;
   logic [4:0]  shamnt_q;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rsp0_result_q, rsp1_result_q;
   logic [7:0]  rsp0_status_q, rsp1_status_q;

   logic        grant0, grant1, accept, acc_owner;
   logic [3:0]  acc_ctrl;
   logic [31:0] acc_op1, acc_op2;
   logic [4:0]  acc_shamnt;
   logic        div0_hit, cap_alu, cap_div0, rsp_hs;

   // Grant is purely combinational; rr_ptr only breaks ties.
   assign grant0     = req0_valid && (!req1_valid || !rr_ptr_q);
   assign grant1     = req1_valid && (!req0_valid || rr_ptr_q);
   assign req0_ready = (state_q == StIdle) && grant0;
   assign req1_ready = (state_q == StIdle) && grant1;
   assign accept     = req0_ready || req1_ready;
   assign acc_owner  = req1_ready;
   assign acc_ctrl   = acc_owner ? req1_ctrl   : req0_ctrl;
   assign acc_op1    = acc_owner ? req1_op1    : req0_op1;
   assign acc_op2    = acc_owner ? req1_op2    : req0_op2;
   assign acc_shamnt = acc_owner ? req1_shamnt : req0_shamnt;

`ifdef ALU_ARB_DIV0_GUARD_EN
   assign div0_hit = (acc_ctrl == DivCtrl) && (acc_op2 == 32'd0);
`else
   assign div0_hit = 1'b0;
`endif

   assign cap_alu  = (state_q == StExec) && (cnt_q == 4'd0);
   assign cap_div0 = accept && div0_hit;
   assign rsp_hs   = (state_q == StResp) && (owner_q ? rsp1_ready : rsp0_ready);

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = div0_hit ? StResp : StSetup;
         end
         StSetup: begin
            state_d = StExec;
            cnt_d   = CntInit;
         end
         StExec: begin
            if (cnt_q == 4'd0) state_d = StResp;
            else               cnt_d   = cnt_q - 4'd1;
         end
         StResp: begin
            if (rsp_hs) begin
               state_d  = StIdle;
               rr_ptr_d = ~owner_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rr_ptr_q <= 1'b0;
         cnt_q    <= 4'd0;
         owner_q  <= 1'b0;
         ctrl_q   <= IDLE_CTRL;
         op1_q    <= 32'd0;
         op2_q    <= 32'd0;
         shamnt_q <= 5'd0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         if (accept) begin
            owner_q  <= acc_owner;
            ctrl_q   <= acc_ctrl;
            op1_q    <= acc_op1;
            op2_q    <= acc_op2;
            shamnt_q <= acc_shamnt;
         end
      end
   end

   // Response registers only change on capture, so they stay stable through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_result_q <= 32'd0;
         rsp0_status_q <= 8'd0;
         rsp1_result_q <= 32'd0;
         rsp1_status_q <= 8'd0;
      end else if (cap_alu) begin
         if (owner_q) begin
            rsp1_result_q <= alu_result;
            rsp1_status_q <= alu_status;
         end else begin
            rsp0_result_q <= alu_result;
            rsp0_status_q <= alu_status;
         end
      end else if (cap_div0) begin
         if (acc_owner) begin
            rsp1_result_q <= 32'd0;
            rsp1_status_q <= 8'b1000_0100;
         end else begin
            rsp0_result_q <= 32'd0;
            rsp0_status_q <= 8'b1000_0100;
         end
      end
   end

   // Opcode only leaves IDLE_CTRL in EXEC, so operands always settle first.
   assign alu_ctrl    = (state_q == StExec) ? ctrl_q : IDLE_CTRL;
   assign alu_op1     = op1_q;
   assign alu_op2     = op2_q;
   assign alu_shamnt  = shamnt_q;
   assign busy        = (state_q != StIdle);
   assign rsp0_valid  = (state_q == StResp) && !owner_q;
   assign rsp1_valid  = (state_q == StResp) && owner_q;
   assign rsp0_result = rsp0_result_q;
   assign rsp0_status = rsp0_status_q;
   assign rsp1_result = rsp1_result_q;
   assign rsp1_status = rsp1_status_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a small behavioural ALU; honours ALU_ARB_DIV0_GUARD_EN.
module tb_alu_arbiter;

   logic        clk, rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]  req0_ctrl, req1_ctrl;
   logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic [4:0]  req0_shamnt, req1_shamnt;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp0_result, rsp1_result;
   logic [7:0]  rsp0_status, rsp1_status;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_op1, alu_op2, alu_result;
   logic [4:0]  alu_shamnt;
   logic [7:0]  alu_status;
   logic        busy;

   typedef struct packed {logic [31:0] res; logic [7:0] st;} exp_t;
   exp_t exp0_q[$];
   exp_t exp1_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
      .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_shamnt(req0_shamnt),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
      .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_shamnt(req1_shamnt),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
      .rsp0_status(rsp0_status),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
      .rsp1_status(rsp1_status),
      .alu_ctrl(alu_ctrl), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_shamnt(alu_shamnt),
      .alu_result(alu_result), .alu_status(alu_status), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU model: status[7]=zero, [5]=carry, [2]=divide-by-zero; IDLE opcode yields 0.
   logic [32:0] sum;
   logic        carry, div0;
   always_comb begin
      sum        = {1'b0, alu_op1} + {1'b0, alu_op2};
      alu_result = 32'd0;
      carry      = 1'b0;
      div0       = 1'b0;
      case (alu_ctrl)
         4'b0010: begin alu_result = sum[31:0]; carry = sum[32]; end
         4'b0110: alu_result = alu_op1 - alu_op2;
         4'b0011: alu_result = alu_op1 ^ alu_op2;
         4'b1001: begin
            if (alu_op2 == 32'd0) begin alu_result = 32'hFFFF_FFFF; div0 = 1'b1; end
            else                  alu_result = alu_op1 / alu_op2;
         end
         default: alu_result = 32'd0;
      endcase
      alu_status = {(alu_result == 32'd0), 1'b0, carry, 2'b00, div0, 2'b00};
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      check(name, {63'd0, busy}, 64'd0);
   endtask

   // Monitor: pops the scoreboard on every response handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (rsp0_valid && rsp0_ready) begin
               if (exp0_q.size() == 0) check("rsp0_unexpected", 64'd1, 64'd0);
               else begin
                  e = exp0_q.pop_front();
                  check("rsp0_result", {32'd0, rsp0_result}, {32'd0, e.res});
                  check("rsp0_status", {56'd0, rsp0_status}, {56'd0, e.st});
               end
            end
            if (rsp1_valid && rsp1_ready) begin
               if (exp1_q.size() == 0) check("rsp1_unexpected", 64'd1, 64'd0);
               else begin
                  e = exp1_q.pop_front();
                  check("rsp1_result", {32'd0, rsp1_result}, {32'd0, e.res});
                  check("rsp1_status", {56'd0, rsp1_status}, {56'd0, e.st});
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int g[$];
      logic [3:0] trace[$];
      int n, pulses, bad;
      logic saw9;

      rst_n = 1'b0;
      req0_valid = 0; req0_ctrl = 0; req0_op1 = 0; req0_op2 = 0; req0_shamnt = 0;
      req1_valid = 0; req1_ctrl = 0; req1_op1 = 0; req1_op2 = 0; req1_shamnt = 0;
      rsp0_ready = 1; rsp1_ready = 1;
      tick(); tick();

      // Reset state
      check("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'hF);
      check("rst_alu_op1", {32'd0, alu_op1}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_valids", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
      check("rst_results", {rsp0_result, rsp1_result}, 64'd0);
      rst_n = 1'b1;
      tick();

      // ADD 5+7 on req0: latency 3, alu_ctrl F,F,2,F
      req0_ctrl = 4'b0010; req0_op1 = 5; req0_op2 = 7; req0_valid = 1;
      #1;
      check("add_ready", {63'd0, req0_ready}, 64'd1);
      check("add_ctrl_idle", {60'd0, alu_ctrl}, 64'hF);
      exp0_q.push_back({32'd12, 8'h00});
      tick();
      req0_valid = 0;
      check("add_ctrl_setup", {60'd0, alu_ctrl}, 64'hF);
      check("add_op1_setup", {32'd0, alu_op1}, 64'd5);
      tick();
      check("add_ctrl_exec", {60'd0, alu_ctrl}, 64'h2);
      check("add_rsp_early", {63'd0, rsp0_valid}, 64'd0);
      tick();
      check("add_ctrl_resp", {60'd0, alu_ctrl}, 64'hF);
      check("add_rsp_lat3", {63'd0, rsp0_valid}, 64'd1);
      wait_idle("add_idle");

      // Round-robin from reset: both valid, expect grants 0,1,0,1
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req0_ctrl = 4'b0110; req0_op1 = 10;   req0_op2 = 3;
      req1_ctrl = 4'b0011; req1_op1 = 'hA5; req1_op2 = 'h0F;
      req0_valid = 1; req1_valid = 1;
      #1;
      n = 0;
      while (g.size() < 4 && n < 100) begin
         if (req0_ready && req1_ready) check("rr_dual_ready", 64'd1, 64'd0);
         if (req0_ready) begin g.push_back(0); exp0_q.push_back({32'd7, 8'h00}); end
         else if (req1_ready) begin g.push_back(1); exp1_q.push_back({32'hAA, 8'h00}); end
         tick();
         n++;
      end
      req0_valid = 0; req1_valid = 0;
      check("rr_grant_count", 64'(g.size()), 64'd4);
      for (int i = 0; i < g.size(); i++) check("rr_grant_order", 64'(g[i]), 64'(i % 2));
      wait_idle("rr_idle");

      // Back-to-back req1 ADD FFFFFFFF+1: two separate opcode pulses
      req1_ctrl = 4'b0010; req1_op1 = 32'hFFFF_FFFF; req1_op2 = 1; req1_valid = 1;
      #1;
      n = 0; pulses = 0;
      while (pulses < 2 && n < 60) begin
         trace.push_back(alu_ctrl);
         if (req1_ready) begin pulses++; exp1_q.push_back({32'd0, 8'hA0}); end
         tick();
         n++;
      end
      req1_valid = 0;
      n = 0;
      while (busy && n < 40) begin
         trace.push_back(alu_ctrl);
         tick();
         n++;
      end
      pulses = 0;
      for (int i = 0; i < trace.size(); i++)
         if (trace[i] == 4'b0010 && (i == 0 || trace[i-1] != 4'b0010)) pulses++;
      check("b2b_add_pulses", 64'(pulses), 64'd2);
      wait_idle("b2b_idle");

      // Response back-pressure on rsp0 while req1 waits
      req0_ctrl = 4'b0010; req0_op1 = 3; req0_op2 = 4; req0_valid = 1; rsp0_ready = 0;
      #1;
      check("bp_req0_ready", {63'd0, req0_ready}, 64'd1);
      exp0_q.push_back({32'd7, 8'h00});
      tick();
      req0_valid = 0;
      req1_ctrl = 4'b0010; req1_op1 = 1; req1_op2 = 1; req1_valid = 1;
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
         check("bp_rsp0_result", {32'd0, rsp0_result}, 64'd7);
         check("bp_req1_blocked", {62'd0, req1_ready, rsp1_valid}, 64'd0);
      end
      rsp0_ready = 1;
      tick();
      check("bp_req1_ready", {63'd0, req1_ready}, 64'd1);
      exp1_q.push_back({32'd2, 8'h00});
      tick();
      req1_valid = 0;
      wait_idle("bp_idle");

      // Reset during EXEC discards the operation
      req0_ctrl = 4'b0010; req0_op1 = 1; req0_op2 = 2; req0_valid = 1;
      tick();
      req0_valid = 0;
      tick();
      check("rx_in_exec", {60'd0, alu_ctrl}, 64'h2);
      rst_n = 1'b0;
      #1;
      check("rx_alu_ctrl", {60'd0, alu_ctrl}, 64'hF);
      check("rx_busy", {63'd0, busy}, 64'd0);
      check("rx_rsp0_result", {32'd0, rsp0_result}, 64'd0);
      check("rx_alu_op", {alu_op1, alu_op2}, 64'd0);
      tick();
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rsp0_valid || rsp1_valid || busy) bad++;
      end
      check("rx_no_rsp", 64'(bad), 64'd0);
      req1_ctrl = 4'b0010; req1_op1 = 2; req1_op2 = 2; req1_valid = 1;
      #1;
      check("rx_next_ready", {63'd0, req1_ready}, 64'd1);
      exp1_q.push_back({32'd4, 8'h00});
      tick();
      req1_valid = 0;
      wait_idle("rx_idle");

      // DIV 8/0 on req0
      req0_ctrl = 4'b1001; req0_op1 = 8; req0_op2 = 0; req0_valid = 1;
      #1;
`ifdef ALU_ARB_DIV0_GUARD_EN
      exp0_q.push_back({32'd0, 8'h84});
`else
      exp0_q.push_back({32'hFFFF_FFFF, 8'h04});
`endif
      check("div_ready", {63'd0, req0_ready}, 64'd1);
      saw9 = 1'b0;
      tick();
      req0_valid = 0;
      n = 0;
      while (!rsp0_valid && n < 20) begin
         if (alu_ctrl == 4'b1001) saw9 = 1'b1;
         tick();
         n++;
      end
      check("div_rsp_seen", {63'd0, rsp0_valid}, 64'd1);
`ifdef ALU_ARB_DIV0_GUARD_EN
      check("div_latency", 64'(n), 64'd0);
      check("div_alu_issued", {63'd0, saw9}, 64'd0);
`else
      check("div_latency", 64'(n), 64'd2);
      check("div_alu_issued", {63'd0, saw9}, 64'd1);
`endif
      wait_idle("div_idle");

      tick(); tick();
      check("sb_empty0", 64'(exp0_q.size()), 64'd0);
      check("sb_empty1", 64'(exp1_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequencer/arbiter that shares the single 32-bit ALU between two requesters (req0 = main datapath, req1 = auxiliary unit).
- Takes one operation at a time over a valid/ready handshake and drives the ALU control, operand and shift-amount inputs.
- Captures the ALU result and 8-bit status after a fixed settle time and returns them on a per-requester response channel.
- Round-robin arbitration between the two requesters.

Parameters:
- ALU_LATENCY, 1, cycles in EXEC between driving the opcode and sampling result/status (legal range 1..15).
- IDLE_CTRL, 4'b1111, opcode driven when no operation is active (ALU default: result 0).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
reqN_valid  in  1  request valid, N=0,1
reqN_ready  out  1  request accepted this cycle, N=0,1
reqN_ctrl  in  4  ALU opcode, N=0,1
reqN_op1  in  32  operand 1, N=0,1
reqN_op2  in  32  operand 2, N=0,1
reqN_shamnt  in  5  shift amount, N=0,1
rspN_valid  out  1  response valid, N=0,1
rspN_ready  in  1  response consumed, N=0,1
rspN_result  out  32  captured ALU result, N=0,1
rspN_status  out  8  captured ALU status, N=0,1
alu_ctrl  out  4  to ALU opcode input
alu_op1  out  32  to ALU operand 1
alu_op2  out  32  to ALU operand 2
alu_shamnt  out  5  to ALU shift amount
alu_result  in  32  from ALU
alu_status  in  8  from ALU
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - alu_ctrl=IDLE_CTRL; alu_op1, alu_op2, alu_shamnt = 0.
  - All ready and valid outputs 0; rspN_result=0, rspN_status=0.
  - An in-flight operation is discarded; no response is ever issued for it.
- States: IDLE -> SETUP -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant is combinational. Only one valid: grant it. Both valid: grant the requester selected by rr_ptr.
  - reqN_ready=1 only for the granted requester and only in IDLE.
  - On valid&&ready: latch ctrl, op1, op2, shamnt and owner ID; go to SETUP.
- SETUP (1 cycle):
  - alu_op1, alu_op2, alu_shamnt = latched values; alu_ctrl stays IDLE_CTRL.
  - Operands are stable before the opcode changes.
- EXEC:
  - alu_ctrl = latched opcode; counter loaded with ALU_LATENCY-1.
  - When counter==0: register alu_result/alu_status into the owner's rsp registers; go to RESP.
- RESP:
  - rsp{owner}_valid=1; result/status held stable until rsp{owner}_ready=1.
  - On handshake: go to IDLE, rr_ptr = ~owner, alu_ctrl back to IDLE_CTRL.
- alu_ctrl always returns to IDLE_CTRL between operations, so back-to-back identical opcodes still present an opcode change to the ALU.
- Latency, accept to rspN_valid: 2+ALU_LATENCY cycles. Throughput: one operation per 3+ALU_LATENCY cycles minimum.
- The non-owner's ready and rsp_valid stay 0 for the whole operation. Request inputs changing after accept have no effect.
- Opcodes are passed through unchecked. An IDLE_CTRL request is executed normally and returns result 0.
- rspN_ready asserted while rspN_valid=0 is ignored.

Optional Feature:
- Macro ALU_ARB_DIV0_GUARD_EN.
- Defined: a request with ctrl=4'b1001 and op2=0 goes IDLE -> RESP directly and is never issued to the ALU. Response is result=32'd0, status=8'b1000_0100 (zero + divide-by-zero). Latency is 1 cycle.
- Undefined: this case is issued like any other opcode; the response carries whatever the ALU returns.

Test Plan:
- ADD via req0 (ctrl=0010, op1=5, op2=7), ALU_LATENCY=1 -> rsp0_valid 3 cycles after accept, result=12, status[7]=0; alu_ctrl sequence F,F,2,F.
- Both valid every cycle; req0 SUB 10-3, req1 XOR A5^0F -> grants alternate 0,1,0,1; rsp0 result=7, rsp1 result=0xAA; no simultaneous readies.
- Back-to-back req1 ADD 0xFFFFFFFF+1 twice -> alu_ctrl shows F between the two 0010 pulses; both responses result=0, status[7]=1, status[5]=1.
- rsp0_ready held 0 for 5 cycles -> rsp0_valid/result stable; req1_valid high but req1_ready=0 until rsp0 handshake.
- rst_n dropped during EXEC -> all outputs at reset values immediately; after release no response issued; next request accepted normally.
- DIV 8/0 on req0 -> with ALU_ARB_DIV0_GUARD_EN: response next cycle, result 0, status 0x84, alu_ctrl never 1001; without: ALU issued, status[2]=1.
